// File: rtl/uart_tx_fifo_if.sv
// Host-side bundle for uart_tx_fifo: byte write port, FIFO status and serial line.
interface uart_tx_fifo_if #(
    parameter int FIFO_DEPTH = 16
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          we;
    logic [7:0]    data_in;
    logic          full;
    logic [CW-1:0] count;
    logic          busy;
    logic          uart_tx;

    modport master (output we, data_in, input full, count, busy, uart_tx);
    modport slave  (input we, data_in, output full, count, busy, uart_tx);
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding an 8N1 UART transmitter; back-to-back frames while bytes are queued.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop (8E1).
//
// state  | meaning
// IDLE   | line high, baud counter held at 0, waiting for a queued byte
// START  | start bit (0)
// DATA   | 8 data bits, LSB first
// PARITY | even parity over the data byte (UART_TX_PARITY_EN only)
// STOP   | stop bit (1); pops the next byte at its end if one is queued
module uart_tx_fifo #(
    parameter int BAUD_DIV   = 434,
    parameter int FIFO_DEPTH = 16
) (
    input logic           clk,
    input logic           rstn,
    uart_tx_fifo_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [15:0]   BAUD_RL  = 16'(BAUD_DIV - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t        state_q, state_d;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [15:0]   baud_q, baud_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          full, push, pop, baud_tick;
    logic [7:0]    head;
`ifdef UART_TX_PARITY_EN
    logic          parity_q, parity_d;
`endif

    assign full      = (count_q == DEPTH_C);
    assign push      = bus.we && !full;
    assign head      = mem[rd_ptr_q];
    assign baud_tick = (baud_q == 16'd0);

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                baud_d = 16'd0;
                if (count_q != '0) pop = 1'b1;
            end
            START: begin
                if (baud_tick) begin
                    state_d   = DATA;
                    tx_d      = shift_q[0];
                    baud_d    = BAUD_RL;
                    bit_idx_d = 3'd0;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    baud_d = BAUD_RL;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = parity_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_tick) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                    baud_d  = BAUD_RL;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
`endif
            STOP: begin
                if (baud_tick) begin
                    if (count_q != '0) begin
                        pop = 1'b1;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                        baud_d  = 16'd0;
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                baud_d  = 16'd0;
            end
        endcase
        // Frame start is shared by IDLE and the no-gap STOP->START path.
        if (pop) begin
            state_d   = START;
            tx_d      = 1'b0;
            baud_d    = BAUD_RL;
            bit_idx_d = 3'd0;
            shift_d   = head;
`ifdef UART_TX_PARITY_EN
            parity_d  = ^head;
`endif
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            baud_q    <= 16'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rstn && push) mem[wr_ptr_q] <= bus.data_in;
    end

    assign bus.full    = full;
    assign bus.count   = count_q;
    assign bus.busy    = (state_q != IDLE) || (count_q != '0);
    assign bus.uart_tx = tx_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at BAUD_DIV=4, FIFO_DEPTH=4; follows UART_TX_PARITY_EN.
module tb_uart_tx_fifo;
    localparam int BD = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic clk = 1'b0;
    logic rstn;
    int   n_cmp = 0;
    int   n_err = 0;
    logic low_seen;

    always #5 clk = ~clk;

    uart_tx_fifo_if #(.FIFO_DEPTH(4)) bus_i ();

    uart_tx_fifo #(.BAUD_DIV(BD), .FIFO_DEPTH(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus_i)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Checks every line cycle of one frame starting at cycle 'skip'; last tick optional.
    task automatic check_frame(input logic [7:0] d, input int skip, input bit end_tick);
        logic [NB-1:0] bits;
        bits[0]   = 1'b0;
        bits[8:1] = d;
`ifdef UART_TX_PARITY_EN
        bits[9]   = ^d;
`endif
        bits[NB-1] = 1'b1;
        for (int i = skip; i < NB*BD; i++) begin
            chk($sformatf("frame_%02h_bit%0d", d, i/BD), {31'd0, bus_i.uart_tx}, {31'd0, bits[i/BD]});
            if (i != NB*BD-1 || end_tick) tick();
        end
    endtask

    task automatic check_quiet(input string tag);
        low_seen = 1'b0;
        repeat (2*NB*BD) begin
            if (!bus_i.uart_tx) low_seen = 1'b1;
            tick();
        end
        chk(tag, {31'd0, low_seen}, 32'd0);
        chk({tag, "_busy"}, {31'd0, bus_i.busy}, 32'd0);
    endtask

    initial begin
        rstn          = 1'b0;
        bus_i.we      = 1'b0;
        bus_i.data_in = 8'h00;
        repeat (3) tick();
        rstn = 1'b1;
        chk("rst_tx",    {31'd0, bus_i.uart_tx}, 32'd1);
        chk("rst_count", {29'd0, bus_i.count},   32'd0);
        chk("rst_full",  {31'd0, bus_i.full},    32'd0);
        chk("rst_busy",  {31'd0, bus_i.busy},    32'd0);
        tick();

        // single byte into idle block
        bus_i.we = 1'b1; bus_i.data_in = 8'h55;
        tick();
        bus_i.we = 1'b0;
        chk("w1_count", {29'd0, bus_i.count},   32'd1);
        chk("w1_busy",  {31'd0, bus_i.busy},    32'd1);
        chk("w1_tx",    {31'd0, bus_i.uart_tx}, 32'd1);
        tick();
        check_frame(8'h55, 0, 1'b1);
        chk("w1_busy_end", {31'd0, bus_i.busy},    32'd0);
        chk("w1_tx_end",   {31'd0, bus_i.uart_tx}, 32'd1);

`ifdef UART_TX_PARITY_EN
        bus_i.we = 1'b1; bus_i.data_in = 8'h07;
        tick();
        bus_i.we = 1'b0;
        tick();
        check_frame(8'h07, 0, 1'b1);
        chk("par_busy_end", {31'd0, bus_i.busy}, 32'd0);
`endif

        // three consecutive writes, back-to-back frames
        bus_i.we = 1'b1; bus_i.data_in = 8'h11;
        tick();
        chk("b2b_count1", {29'd0, bus_i.count}, 32'd1);
        bus_i.data_in = 8'h22;
        tick();
        chk("b2b_count2", {29'd0, bus_i.count},   32'd1);
        chk("b2b_start",  {31'd0, bus_i.uart_tx}, 32'd0);
        bus_i.data_in = 8'h33;
        tick();
        bus_i.we = 1'b0;
        chk("b2b_peak", {29'd0, bus_i.count}, 32'd2);
        check_frame(8'h11, 1, 1'b1);
        check_frame(8'h22, 0, 1'b1);
        check_frame(8'h33, 0, 1'b1);
        chk("b2b_busy_end", {31'd0, bus_i.busy}, 32'd0);

        // overflow: six writes into depth 4, last one dropped
        for (int i = 0; i < 6; i++) begin
            bus_i.we = 1'b1; bus_i.data_in = 8'hA0 + 8'(i);
            tick();
            if (i == 4) chk("ovf_full_w5", {31'd0, bus_i.full}, 32'd1);
        end
        bus_i.we = 1'b0;
        chk("ovf_count", {29'd0, bus_i.count}, 32'd4);
        chk("ovf_full",  {31'd0, bus_i.full},  32'd1);
        check_frame(8'hA0, 4, 1'b1);
        for (int i = 1; i < 5; i++) check_frame(8'hA0 + 8'(i), 0, 1'b1);
        check_quiet("ovf_quiet");

        // write while full on the same edge as a pop
        for (int i = 0; i < 5; i++) begin
            bus_i.we = 1'b1; bus_i.data_in = 8'hB0 + 8'(i);
            tick();
        end
        bus_i.we = 1'b0;
        chk("wp_full", {31'd0, bus_i.full}, 32'd1);
        check_frame(8'hB0, 3, 1'b0);
        bus_i.we = 1'b1; bus_i.data_in = 8'hC5;
        tick();
        bus_i.we = 1'b0;
        chk("wp_count", {29'd0, bus_i.count}, 32'd3);
        chk("wp_full2", {31'd0, bus_i.full},  32'd0);
        for (int i = 1; i < 5; i++) check_frame(8'hB0 + 8'(i), 0, 1'b1);
        check_quiet("wp_quiet");

        // reset during data bit 3 with two bytes queued
        bus_i.we = 1'b1; bus_i.data_in = 8'h3C;
        tick();
        bus_i.data_in = 8'h5A;
        tick();
        bus_i.data_in = 8'h96;
        tick();
        bus_i.we = 1'b0;
        chk("mr_count", {29'd0, bus_i.count}, 32'd2);
        repeat (16) tick();
        chk("mr_bit3", {31'd0, bus_i.uart_tx}, 32'd1);
        rstn = 1'b0; bus_i.we = 1'b1; bus_i.data_in = 8'hEE;
        tick();
        rstn = 1'b1; bus_i.we = 1'b0;
        chk("mr_tx",    {31'd0, bus_i.uart_tx}, 32'd1);
        chk("mr_count2", {29'd0, bus_i.count},  32'd0);
        chk("mr_busy",  {31'd0, bus_i.busy},    32'd0);
        chk("mr_full",  {31'd0, bus_i.full},    32'd0);
        check_quiet("mr_quiet");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 The block SHALL expose parameter BAUD_DIV, default 434, giving clk cycles per serial bit (50 MHz / 115200); legal range 2..65535.
REQ-002 The block SHALL expose parameter FIFO_DEPTH, default 16, giving FIFO entries; power of two, 2..256.
REQ-003 Port clk SHALL be input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 Port rstn SHALL be input, 1 bit: reset, synchronous and active-low.
REQ-005 Port we SHALL be input, 1 bit: write strobe; one byte is offered per asserted cycle.
REQ-006 Port data_in SHALL be input, 8 bits: byte written when we=1.
REQ-007 Port full SHALL be output, 1 bit: high when count equals FIFO_DEPTH.
REQ-008 Port count SHALL be output, clog2(FIFO_DEPTH)+1 bits: number of queued bytes, excluding the byte being shifted.
REQ-009 Port busy SHALL be output, 1 bit: high when state is not IDLE or count is nonzero.
REQ-010 Port uart_tx SHALL be output, 1 bit: serial line, idle high, registered.

Function
REQ-011 A write SHALL be accepted at an edge where we=1 and full=0 (full as registered before that edge); a write while full=1 SHALL be dropped and leave FIFO contents and count unchanged.
REQ-012 Write and pop at the same edge SHALL leave count unchanged; the write is accepted if full=0 beforehand, even when a pop occurs.
REQ-013 Bytes SHALL be transmitted in write order, with the FIFO pointers wrapping modulo FIFO_DEPTH.
REQ-014 The FSM SHALL have these states:
- IDLE
- START
- DATA
- PARITY (present only with the macro)
- STOP
REQ-015 In IDLE with count>0, the next edge SHALL pop the head byte into the shift register, enter START and drive uart_tx=0. When the byte was written into an empty FIFO, uart_tx SHALL therefore fall one cycle after the write edge.
REQ-016 Each bit SHALL be held on uart_tx for exactly BAUD_DIV cycles, timed by a baud counter that reloads on every bit transition.
REQ-017 DATA SHALL shift 8 bits, LSB first, counted by a 3-bit index; after bit 7 the FSM SHALL go to PARITY (macro defined) or STOP.
REQ-018 STOP SHALL drive uart_tx=1 for BAUD_DIV cycles. At its end:
- count>0: enter START directly, popping the next byte (no idle gap).
- otherwise: enter IDLE.
REQ-019 In IDLE, uart_tx SHALL be 1 and the baud counter SHALL be held at 0.
REQ-020 The byte in flight SHALL be unaffected by FIFO writes, drops or full conditions.

Reset
REQ-021 On an edge where rstn=0, the following SHALL take effect from the next cycle:
- state = IDLE, uart_tx = 1
- count = 0, full = 0, busy = 0
- FIFO pointers, baud counter and bit index cleared
REQ-022 Reset mid-frame SHALL abort the frame (uart_tx returns high at once) and discard all queued bytes; writes during reset SHALL be ignored.

Configuration
REQ-023 Macro UART_TX_PARITY_EN defined: frame SHALL be start, 8 data, even-parity bit (XOR of the data bits), stop = 11 bits, and the PARITY state exists.
REQ-024 Macro UART_TX_PARITY_EN undefined: frame SHALL be start, 8 data, stop = 10 bits, with no PARITY state or logic.

Verification
REQ-025 BAUD_DIV=4, no parity, write 0x55 into an idle block -> uart_tx = 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles, first bit one cycle after the write edge; busy falls after 40 cycles.
REQ-026 BAUD_DIV=4, parity enabled, write 0x55 -> parity bit 0, 11-bit frame of 44 cycles; write 0x07 -> parity bit 1.
REQ-027 Write 0x11, 0x22, 0x33 on consecutive cycles -> count peaks at 2; three frames back-to-back with no high cycles beyond the stop bits; bytes arrive in order.
REQ-028 FIFO_DEPTH=4, 6 consecutive writes of 0xA0..0xA5 while the first frame shifts -> 0xA0 in flight, 0xA1..0xA4 queued, full=1, 0xA5 dropped; exactly five frames are emitted.
REQ-029 rstn=0 for 1 cycle during bit 3 of a frame with 2 bytes queued -> next cycle uart_tx=1, count=0, busy=0; no further frames.
REQ-030 With count=FIFO_DEPTH, a write on the same edge as a pop -> write dropped, count becomes FIFO_DEPTH-1.
